dsp_row_sequencer: RTL
======================

Name: dsp_row_sequencer

Overview:
- Sequences one generic 17x17 DSP slice to compute a row of operand-scanning multiprecision multiplication: R = a*B + T.
- a is one 17-bit word. B and T are NWORDS-word operands of 17 bits per word, streamed in least significant word first.
- The block issues OPMODE, A, B, C and CREG_en to the DSP, aligns them to its internal pipeline depth, and chains carries with the P>>17 feedback.
- It emits NWORDS+1 result words. It sits between the FIOS loop controller and one DSP instance.

Parameters:
- NWORDS, 16: number of 17-bit words in B and T. Must be at least 2.
- ABREG, 1: must equal the DSP's ABREG.
- MREG, 1: must equal the DSP's MREG. ABREG+MREG must be at least 1.
- CREG, 1: must equal the DSP's CREG.

Ports:
- clock_i  in  1  clock
- reset_i  in  1  asynchronous active-high reset
- start_i  in  1  starts a row when in IDLE; ignored otherwise
- a_i  in  17  multiplier word, captured on an accepted start
- in_valid_i  in  1  b_word_i/t_word_i valid
- in_ready_o  out  1  high only in RUN
- b_word_i  in  17  current B word
- t_word_i  in  17  current T word
- dsp_OPMODE_o  out  9  to DSP OPMODE_i
- dsp_A_o  out  17  to DSP A_i
- dsp_B_o  out  17  to DSP B_i
- dsp_C_o  out  34  to DSP C_i, zero-extended T word
- dsp_CREG_en_o  out  1  to DSP CREG_en_i
- dsp_P_i  in  34  from DSP P_o
- res_valid_o  out  1  result word valid, one cycle
- res_word_o  out  17  result word
- res_idx_o  out  $clog2(NWORDS+1)  result word index, 0..NWORDS
- busy_o  out  1  high from accepted start until done
- done_o  out  1  one-cycle pulse after the last result word

Behaviour:
- Reset, asynchronous: state goes to IDLE. All outputs go to 0, including OPMODE 9'b0, and all delay lines are cleared.
- Let L = ABREG+MREG. A word accepted at cycle k, where in_valid_i and in_ready_o are both high:
  - dsp_A_o and dsp_B_o are driven at cycle k.
  - dsp_C_o and dsp_CREG_en_o=1 are driven at cycle k+L-CREG.
  - dsp_OPMODE_o is driven at cycle k+L-1.
  - dsp_P_i is sampled at cycle k+L+1.
- Fixed internal delay lines provide this alignment. dsp_CREG_en_o is 0 whenever no C word is due.
- OPMODE encodings:
  - First word: 9'b11_000_0101, P = M + C.
  - Later words: 9'b11_110_0101, P = M + C + (P>>17).
  - Bubble: 9'b00_010_0000, P held.
  - Flush: 9'b00_110_0000, P = P>>17.
  - Idle: 9'b0.
- IDLE state:
  - in_ready_o=0. dsp_A_o is held at 0.
  - On start_i, capture a_i, clear the word counter, set busy_o, and go to RUN.
- RUN state:
  - in_ready_o=1.
  - Each accepted word increments the counter and schedules a first or later OPMODE.
  - A cycle with no accepted word schedules a bubble. The bubble holds P, so it never corrupts the carry.
  - When the NWORDS-th word is accepted, go to FLUSH. in_ready_o falls on the next cycle.
- FLUSH state:
  - Schedules exactly one flush OPMODE, in the cycle after the last accepted word. Then go to DRAIN.
- DRAIN state:
  - Waits until the flush result has been sampled.
- Result output:
  - For each scheduled word or flush, on the sampling cycle: res_valid_o=1, res_word_o=dsp_P_i[16:0], res_idx_o = word index, with the flush at index NWORDS.
  - Bubbles produce no res_valid_o.
  - All result outputs are registered, so they appear 1 cycle after the sample.
- Completion: done_o pulses in the cycle after res_idx_o=NWORDS is valid. busy_o clears in that same cycle and the state returns to IDLE.
- Width and arithmetic:
  - a*b + t + carry < 2^34, so the carry after P>>17 always fits in 17 bits and the flush word is the exact top word.
  - No overflow handling is needed.
- start_i while busy is ignored. A start in the same cycle as done_o is ignored; a new start requires IDLE.
- Reset mid-row aborts the row with no done_o. The next row is correct because its first word uses Z=0.

Test Plan:
- NWORDS=4, a=2, B={1,2,3,4}, T=0, in_valid_i held high -> results idx0..4 = 2, 4, 6, 8, 0, one per cycle; done_o one cycle after idx4.
- NWORDS=4, a=0x1FFFF, all B and T words 0x1FFFF -> results 0x00000, 0x1FFFF, 0x1FFFF, 0x1FFFF, 0x1FFFF. This exercises a full carry chain.
- Same operands as the previous scenario, with in_valid_i low for 3 cycles between words 1 and 2 -> identical result words and indices; no res_valid_o during the gap.
- Check OPMODE/C/A alignment for (ABREG,MREG,CREG) = (1,1,1), (0,1,0) and (1,0,1) -> each: dsp_P_i sampled L+1 cycles after acceptance; case-1 results unchanged.
- start_i pulsed mid-row -> ignored; row completes normally.
- reset_i asserted after word 2, then a new row with case-1 operands -> all outputs 0 during reset; no done_o for the aborted row; new results 2, 4, 6, 8, 0.

Source files
------------

// File: rtl/dsp_row_sequencer_if.sv
// dsp_row_sequencer_if: row handshake, DSP control and result bundle between
// the FIOS loop controller, the row sequencer and one DSP slice.
interface dsp_row_sequencer_if #(parameter int NWORDS = 16);
  localparam int IW = $clog2(NWORDS + 1);
  logic start_i;
  logic [16:0] a_i;
  logic in_valid_i;
  logic in_ready_o;
  logic [16:0] b_word_i;
  logic [16:0] t_word_i;
  logic [8:0] dsp_OPMODE_o;
  logic [16:0] dsp_A_o;
  logic [16:0] dsp_B_o;
  logic [33:0] dsp_C_o;
  logic dsp_CREG_en_o;
  logic [33:0] dsp_P_i;
  logic res_valid_o;
  logic [16:0] res_word_o;
  logic [IW-1:0] res_idx_o;
  logic busy_o;
  logic done_o;
  modport slave (
    input start_i, a_i, in_valid_i, b_word_i, t_word_i, dsp_P_i,
    output in_ready_o, dsp_OPMODE_o, dsp_A_o, dsp_B_o, dsp_C_o, dsp_CREG_en_o,
    output res_valid_o, res_word_o, res_idx_o, busy_o, done_o
  );
  modport master (
    output start_i, a_i, in_valid_i, b_word_i, t_word_i, dsp_P_i,
    input in_ready_o, dsp_OPMODE_o, dsp_A_o, dsp_B_o, dsp_C_o, dsp_CREG_en_o,
    input res_valid_o, res_word_o, res_idx_o, busy_o, done_o
  );
endinterface

// File: rtl/dsp_row_sequencer.sv
// dsp_row_sequencer: drives one 17x17 DSP slice through a row R = a*B + T,
// aligning C/OPMODE/P-sample to the slice pipeline and chaining carries via P>>17.
module dsp_row_sequencer #(
  parameter int NWORDS = 16,
  parameter int ABREG = 1,
  parameter int MREG = 1,
  parameter int CREG = 1
) (
  input logic clock_i,
  input logic reset_i,
  dsp_row_sequencer_if.slave io
);
  localparam int L = ABREG + MREG;
  localparam int IW = $clog2(NWORDS + 1);
  localparam int CD = L - CREG;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;
  typedef enum logic [2:0] {K_IDLE, K_BUBBLE, K_FIRST, K_LATER, K_FLUSH} kind_t;
  state_t state, state_n;
  kind_t cur_k, op_k, c_k;
  kind_t kind_q [1:L+1];
  logic [IW-1:0] cur_i;
  logic [IW-1:0] idx_q [1:L+1];
  logic [16:0] a_q, c_t;
  logic [IW-1:0] cnt;
  logic accept, last, c_word;
  assign accept = state == RUN && io.in_valid_i;
  assign last = accept && cnt == IW'(NWORDS - 1);
  always_comb begin
    state_n = state;
    cur_k = K_IDLE;
    cur_i = cnt;
    if (state == IDLE && io.start_i && !io.done_o) state_n = RUN;
    if (state == RUN) begin
      cur_k = !accept ? K_BUBBLE : cnt == '0 ? K_FIRST : K_LATER;
      if (last) state_n = FLUSH;
    end
    if (state == FLUSH) begin
      cur_k = K_FLUSH;
      cur_i = IW'(NWORDS);
      state_n = DRAIN;
    end
    if (state == DRAIN && io.res_valid_o && io.res_idx_o == IW'(NWORDS)) state_n = IDLE;
  end
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
      a_q <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && state_n == RUN) begin
        a_q <= io.a_i;
        cnt <= '0;
      end else if (accept) cnt <= cnt + IW'(1);
    end
  end
  // Stage j of the slot line holds what was scheduled j cycles ago.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 1; i <= L + 1; i++) begin
        kind_q[i] <= K_IDLE;
        idx_q[i] <= '0;
      end
    end else begin
      kind_q[1] <= cur_k;
      idx_q[1] <= cur_i;
      for (int i = 2; i <= L + 1; i++) begin
        kind_q[i] <= kind_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end
  if (L == 1) begin : g_op0
    assign op_k = cur_k;
  end else begin : g_op
    assign op_k = kind_q[L-1];
  end
  if (CD == 0) begin : g_c0
    assign c_k = cur_k;
    assign c_t = io.t_word_i;
  end else begin : g_c
    logic [16:0] t_q [1:CD];
    always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) for (int i = 1; i <= CD; i++) t_q[i] <= '0;
      else begin
        t_q[1] <= io.t_word_i;
        for (int i = 2; i <= CD; i++) t_q[i] <= t_q[i-1];
      end
    end
    assign c_k = kind_q[CD];
    assign c_t = t_q[CD];
  end
  assign c_word = c_k == K_FIRST || c_k == K_LATER;
  assign io.in_ready_o = state == RUN;
  assign io.busy_o = state != IDLE;
  assign io.dsp_A_o = state == RUN ? a_q : '0;
  assign io.dsp_B_o = state == RUN ? io.b_word_i : '0;
  assign io.dsp_CREG_en_o = c_word;
  assign io.dsp_C_o = c_word ? {17'b0, c_t} : '0;
  assign io.dsp_OPMODE_o = op_k == K_FIRST  ? 9'b11_000_0101 :
                           op_k == K_LATER  ? 9'b11_110_0101 :
                           op_k == K_BUBBLE ? 9'b00_010_0000 :
                           op_k == K_FLUSH  ? 9'b00_110_0000 : 9'b0;
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      io.res_valid_o <= 1'b0;
      io.res_word_o <= '0;
      io.res_idx_o <= '0;
      io.done_o <= 1'b0;
    end else begin
      io.res_valid_o <= kind_q[L+1] inside {K_FIRST, K_LATER, K_FLUSH};
      if (kind_q[L+1] inside {K_FIRST, K_LATER, K_FLUSH}) begin
        io.res_word_o <= io.dsp_P_i[16:0];
        io.res_idx_o <= idx_q[L+1];
      end
      io.done_o <= io.res_valid_o && io.res_idx_o == IW'(NWORDS);
    end
  end
endmodule
